// File: rtl/bcd_result_encoder.sv
// Sequential signed-binary to sign-magnitude BCD converter (shift-add-3, one bit per clock).
// Optional macro BCD_LEADING_BLANK_EN replaces leading zero digits above digit 0 with code 11 (blank).
module bcd_result_encoder #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [1:0]            o_dbg_state
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  // Handshake: start is accepted on any rising edge where the FSM sits in IDLE;
  // busy covers the cycle after acceptance through the done cycle, and done is a
  // single-cycle pulse marking a fresh, stable sign/bcd result.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_count;
  logic [IN_W-1:0] r_mag;
  logic [BW-1:0]   r_scratch;
  logic [BW-1:0]   r_bcd;
  logic            r_sign_cap;
  logic            r_sign;
  logic            r_done;
  logic [IN_W-1:0] w_mag_in;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_final;

  // Two's-complement negate is exact for the most negative value (0x8000 -> 0x8000 unsigned).
  assign w_mag_in = value[IN_W-1] ? (~value + IN_W'(1)) : value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_count == CW'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
    end
  end

`ifdef BCD_LEADING_BLANK_EN
  logic w_lead;
  always_comb begin
    w_final = r_scratch;
    w_lead  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (w_lead && (r_scratch[4*k +: 4] == 4'd0)) w_final[4*k +: 4] = 4'd11;
      else                                         w_lead = 1'b0;
    end
  end
`else
  always_comb begin
    w_final = r_scratch;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_mag      <= '0;
      r_scratch  <= '0;
      r_bcd      <= '0;
      r_sign_cap <= 1'b0;
      r_sign     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign_cap <= value[IN_W-1];
            r_mag      <= w_mag_in;
            r_scratch  <= '0;
            r_count    <= CW'(IN_W);
          end
        end
        S_SHIFT: begin
          r_scratch <= {w_adj[BW-2:0], r_mag[IN_W-1]};
          r_mag     <= {r_mag[IN_W-2:0], 1'b0};
          r_count   <= r_count - CW'(1);
        end
        S_DONE: begin
          // A zero scratch means a zero magnitude, so no minus sign is shown.
          r_bcd  <= w_final;
          r_sign <= r_sign_cap & (|r_scratch);
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE) | r_done;
  assign done        = r_done;
  assign sign        = r_sign;
  assign bcd         = r_bcd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bcd_result_encoder.sv
// Directed + randomized bench for bcd_result_encoder using a decimal-arithmetic reference model.
module tb_bcd_result_encoder;
  localparam int IN_W   = 16;
  localparam int DIGITS = 5;
  localparam int BW     = 4 * DIGITS;

  logic            clk;
  logic            rst;
  logic            start;
  logic [IN_W-1:0] value;
  logic            busy;
  logic            done;
  logic            sign;
  logic [BW-1:0]   bcd;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [BW:0] exp_q[$];
  logic [BW:0] last_res;

  bcd_result_encoder #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .value       (value),
    .busy        (busy),
    .done        (done),
    .sign        (sign),
    .bcd         (bcd),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {sign, digits} from plain decimal arithmetic on the signed value.
  function automatic logic [BW:0] model(input logic [IN_W-1:0] v);
    int          m;
    int          d[DIGITS];
    logic [BW:0] r;
    bit          lead;
    m = v[IN_W-1] ? (65536 - int'(v)) : int'(v);
    for (int k = 0; k < DIGITS; k++) d[k] = (m / (10 ** k)) % 10;
`ifdef BCD_LEADING_BLANK_EN
    lead = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && d[k] == 0) d[k] = 11;
      else                   lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    r = '0;
    r[BW] = (m != 0) && v[IN_W-1];
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'(d[k]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion; optional extra start pulse at cycle inj_cyc that must be ignored.
  task automatic run_conv(input logic [IN_W-1:0] v, input int inj_cyc, input logic [IN_W-1:0] inj_v);
    int          cyc;
    bit          got;
    logic [BW:0] res;
    exp_q.push_back(model(v));
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
    value = IN_W'($urandom);
    got = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == inj_cyc) begin
        start = 1'b1;
        value = inj_v;
      end
      if (cyc == 3 || cyc == 10) check("hold_prev", 32'({sign, bcd}), 32'(last_res));
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'd17);
    res = exp_q.pop_front();
    if (got) begin
      check("result", 32'({sign, bcd}), 32'(res));
      check("busy_in_done", 32'(busy), 32'd1);
      last_res = res;
      tick();
      check("done_pulse", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int          dn;
    int          done_cyc[$];
    logic [BW:0] res;

    rst      = 1'b0;
    start    = 1'b0;
    value    = '0;
    last_res = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out",  32'({sign, bcd}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Directed cases; the 999 start at cycle 5 must be ignored.
    run_conv(16'd1234, 5, 16'd999);
    run_conv(16'd999, 0, 16'd0);
    run_conv(16'h8000, 0, 16'd0);
    run_conv(16'hFFFF, 0, 16'd0);
    run_conv(16'd0, 0, 16'd0);
    run_conv(16'h7FFF, 0, 16'd0);

    // Asynchronous reset in SHIFT cycle 8: outputs clear at once, no done follows.
    start = 1'b1;
    value = 16'd500;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_out",  32'({sign, bcd}), 32'd0);
    tick();
    rst = 1'b1;
    last_res = '0;
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) dn++;
    end
    check("arst_no_done", 32'(dn), 32'd0);
    run_conv(16'd42, 0, 16'd0);

    // start held high with -7: back-to-back conversions.
    start = 1'b1;
    value = 16'hFFF9;
    tick();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (done) begin
        done_cyc.push_back(cyc);
        check("held_result", 32'({sign, bcd}), 32'(model(16'hFFF9)));
      end
    end
    start = 1'b0;
    check("held_count", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() >= 2) begin
      check("held_first", 32'(done_cyc[0]), 32'd17);
      check("held_second", 32'(done_cyc[1]), 32'd35);
    end
    dn = 0;
    for (int i = 0; i < 30 && busy; i++) tick();
    check("held_drain", 32'(busy), 32'd0);
    last_res = model(16'hFFF9);

    // Randomized operands
    for (int i = 0; i < 16; i++) begin
      res = '0;
      run_conv(IN_W'($urandom_range(0, 65535)), 0, 16'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_result_encoder.md
Name: bcd_result_encoder

Overview:
- Sequential signed-binary to sign-magnitude BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits between the multiplier datapath and the seven-segment display driver.
- Produces the sign flag and the per-digit BCD codes that the display driver consumes.
- Holds its last result stable on the outputs while a new conversion runs.

Parameters:
- IN_W, 16, width of the signed two's-complement input.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^(IN_W-1). Default covers magnitude 32768.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  conversion request, sampled only in IDLE.
- value  in  IN_W  signed two's-complement operand, captured on the accepted start.
- busy  out  1  high from the cycle after start is accepted until done is asserted, inclusive of the done cycle.
- done  out  1  one-cycle pulse when a new result is on sign/bcd.
- sign  out  1  1 = negative (display shows minus), 0 = zero or positive.
- bcd  out  4*DIGITS  digit k at bits [4k+3:4k], k=0 is the least significant digit.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, busy=0, done=0, sign=0, bcd=all zero, internal shift/count registers zero. Reset mid-conversion aborts with no done pulse.
- State IDLE: busy=0.
  - start=1 at a clock edge: capture sign_r = value[IN_W-1].
  - Capture magnitude = |value| as an unsigned IN_W-bit number. The most negative value, e.g. -32768, gives 0x8000 with no overflow.
  - Clear the BCD scratch register, load count = IN_W, go to SHIFT.
- State SHIFT: busy=1. Each cycle:
  - For every scratch digit >= 5, add 3 (all digits in parallel, 4-bit, no carry between digits).
  - Then shift {scratch, magnitude} left by 1.
  - Decrement count. When count reaches 1, the last shift occurs and next state is DONE.
  - This is exactly IN_W SHIFT cycles.
- State DONE: busy=1.
  - Copy scratch to the bcd output register and sign_r to sign.
  - Force sign=0 if the magnitude was zero.
  - Assert done for this single cycle, then go to IDLE.
- Latency: start sampled at edge 0; done, sign and bcd valid after edge IN_W+1 (17 cycles at default).
- Outputs sign/bcd change only on entry to DONE. During IDLE/SHIFT they hold the previous result, so the display never shows partial values.
- start while busy (SHIFT or DONE) is ignored, with no queuing. start held high continuously restarts a conversion on the first IDLE cycle after each done.
- value may change freely after capture.
- Scratch digit width is exactly 4 bits. Given the DIGITS constraint, no digit ever exceeds 9 at the end.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined:
  - In the DONE cycle, every leading zero digit above digit 0 is replaced by code 4'd11 (display blank).
  - Scanning runs from digit DIGITS-1 down and stops at the first non-zero digit.
  - Digit 0 is never blanked.
  - Codes 10 and 11 never otherwise appear.
- Not defined: all digits are output as plain BCD 0-9, leading zeros included.
- Latency, handshake and sign behaviour are identical in both builds.

Test Plan:
- value=16'sd1234, start one cycle:
  - Without macro: done 17 cycles later, sign=0, bcd digits (4..0)=0,1,2,3,4.
  - With macro: 11,0x0B... i.e. digits 4..0 = 11,1,2,3,4.
- value=-32768: sign=1, digits 3,2,7,6,8. value=-1: sign=1, digits 0,0,0,0,1 (macro: 11,11,11,11,1).
- value=0: sign=0, all digits 0. With macro: 11,11,11,11,0. done pulses exactly one cycle.
- First convert 1234, then start=1 with value=999 at cycle 5 of that conversion: ignored.
  - Result is 1234 and bcd holds it until a later accepted start of 999 completes.
  - Previous result stays visible throughout.
- Drop rst low in SHIFT cycle 8: all outputs 0 immediately (asynchronous), no done.
  - After release, start with 42 yields digits 0,0,0,4,2 after 17 cycles.
- Hold start=1 with value=-7 for 40 cycles:
  - done pulses at cycles 17 and 35 (one IDLE cycle between conversions).
  - sign=1, digits 0,0,0,0,7 each time.
